// File: rtl/data_mem_resp.sv
// Data-memory responder: RV32I loads/stores on a 2**ADDR_W x 32-bit array behind a
// valid/ready request handshake, with a held response. SB/SH use a read-modify-write cycle.
// Optional build macro: DMEM_MISALIGN_CHECK_EN flags misaligned half/word accesses as errors
// (no array access). Without it, byte_off[0] is ignored for halves and byte_off for words.
module data_mem_resp #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned LATENCY = 2   // legal range 1..7
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_byte_off,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [2:0]  CntInit = 3'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StRmwWr, StResp} state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [31:0]         mem_q [Depth];

  logic                mem_we;
  logic [31:0]         mem_wdata;
  logic [31:0]         old_word;
  logic                bad_f3;
  logic                misalign;

  // Sign/zero-extend the addressed lane of a word according to the load funct3.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'b0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'b0, h};
      3'b010:  load_ext = w;
      default: load_ext = 32'b0;
    endcase
  endfunction

  // Merge a right-aligned byte (half=0) or half (half=1) into the old word at its lane.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic half, input logic [1:0] off);
    logic [4:0]  sh;
    logic [31:0] mask;
    sh   = half ? {off[1], 4'b0000} : {off, 3'b000};
    mask = (half ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    store_merge = (old & ~mask) | ((wd << sh) & mask);
  endfunction

  assign old_word = mem_q[addr_q];

  // Decode errors from the latched request fields.
  always_comb begin
    bad_f3   = we_q ? (f3_q > 3'b010) : (f3_q == 3'b011 || f3_q[2:1] == 2'b11);
    misalign = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = (f3_q[1:0] == 2'b01 && off_q[0]) || (f3_q[1:0] == 2'b10 && off_q != 2'b00);
`endif
  end

  // Next-state, datapath and array-write decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_wdata = 32'b0;
    req_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = !Reset;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          off_d   = req_byte_off;
          wdata_d = req_wdata;
          cnt_d   = CntInit;
          rdata_d = 32'b0;
          err_d   = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 3'b000) begin
          cnt_d = cnt_q - 3'b001;
        end else if (bad_f3) begin
          err_d   = 1'b1;
          rdata_d = 32'b0;
          state_d = StResp;
        end else if (!we_q) begin
          err_d   = misalign;
          rdata_d = misalign ? 32'b0 : load_ext(old_word, f3_q, off_q);
          state_d = StResp;
        end else if (f3_q == 3'b010) begin
          err_d     = misalign;
          mem_we    = !misalign;
          mem_wdata = wdata_q;
          state_d   = StResp;
        end else begin
          // Misaligned SH still spends the RMW cycle so timing matches a legal access.
          err_d   = misalign;
          state_d = StRmwWr;
        end
      end
      StRmwWr: begin
        mem_we    = !err_q;
        mem_wdata = store_merge(old_word, wdata_q, f3_q[0], off_q);
        state_d   = StResp;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and request/response registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 3'b000;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      off_q   <= 2'b00;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array; reset clears it and drops any pending write.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= 32'b0;
    end else if (mem_we) begin
      mem_q[addr_q] <= mem_wdata;
    end
  end

  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed test-plan steps followed by random traffic,
// each compared against a word-array reference model.
module tb_data_mem_resp;

  localparam int Lat = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [4:0]  req_addr;
  logic [1:0]  req_byte_off;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m [32];
  logic [31:0] last_rdata;
  logic        last_err;

  data_mem_resp #(.ADDR_W(5), .LATENCY(Lat)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_byte_off (req_byte_off),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Reference: expected result of one request, updating the model array for stores.
  task automatic model(input logic we, input logic [2:0] f3, input logic [4:0] addr,
                       input logic [1:0] off, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat);
    logic        bad, mis;
    logic [31:0] w, v;
    int unsigned sh;
    bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    mis = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis = ((f3 == 3'd1 || f3 == 3'd5) && off[0]) || (f3 == 3'd2 && off != 2'd0);
`endif
    lat = (we && !bad && f3 < 3'd2) ? Lat + 1 : Lat;
    rd  = 32'd0;
    err = bad || mis;
    w   = mem_m[addr];
    if (!err && !we) begin
      case (f3)
        3'd0, 3'd4: begin
          v  = (w >> (8 * off)) & 32'd255;
          rd = (f3 == 3'd0 && v >= 32'd128) ? v + 32'hFFFF_FF00 : v;
        end
        3'd1, 3'd5: begin
          v  = (w >> (16 * off[1])) & 32'd65535;
          rd = (f3 == 3'd1 && v >= 32'd32768) ? v + 32'hFFFF_0000 : v;
        end
        default: rd = w;
      endcase
    end else if (!err) begin
      if (f3 == 3'd2) mem_m[addr] = wd;
      else begin
        sh = (f3 == 3'd0) ? 8 * off : 16 * off[1];
        v  = (f3 == 3'd0) ? 32'd255 : 32'd65535;
        mem_m[addr] = (w & ~(v << sh)) | ((wd & v) << sh);
      end
    end
  endtask

  // One full transaction with resp_ready held high; checks latency and response.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [4:0] addr, input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] erd;
    logic        eerr;
    int          elat, cyc;
    model(we, f3, addr, off, wd, erd, eerr, elat);
    chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_byte_off = off; req_wdata = wd;
    step();
    req_valid = 1'b0;
    cyc = 0;
    while (!resp_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, "/latency"}, 32'(cyc), 32'(elat));
    chk({tag, "/rdata"}, resp_rdata, erd);
    chk({tag, "/err"}, 32'(resp_err), 32'(eerr));
    last_rdata = resp_rdata;
    last_err   = resp_err;
    step();
    chk({tag, "/valid_drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] erd;
    logic        eerr;
    int          elat, cyc;
    for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
    Reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 5'd0;
    req_byte_off = 2'd0; req_wdata = 32'd0; resp_ready = 1'b1;
    step(); step();
    chk("reset/req_ready", 32'(req_ready), 32'd0);
    chk("reset/resp_valid", 32'(resp_valid), 32'd0);
    chk("reset/resp_rdata", resp_rdata, 32'd0);
    chk("reset/resp_err", 32'(resp_err), 32'd0);
    Reset = 1'b0;
    step();
    chk("post_reset/req_ready", 32'(req_ready), 32'd1);

    // Word store/load and byte read-modify-write.
    do_req("sw3", 1'b1, 3'd2, 5'd3, 2'd0, 32'hDEAD_BEEF);
    do_req("lw3", 1'b0, 3'd2, 5'd3, 2'd0, 32'd0);
    chk("lw3/const", last_rdata, 32'hDEAD_BEEF);
    do_req("sb3", 1'b1, 3'd0, 5'd3, 2'd1, 32'h0000_00AA);
    do_req("lw3b", 1'b0, 3'd2, 5'd3, 2'd0, 32'd0);
    chk("lw3b/const", last_rdata, 32'hDEAD_AAEF);

    // Load extension.
    do_req("sw5", 1'b1, 3'd2, 5'd5, 2'd0, 32'h8001_F0FF);
    do_req("lb5", 1'b0, 3'd0, 5'd5, 2'd0, 32'd0);
    chk("lb5/const", last_rdata, 32'hFFFF_FFFF);
    do_req("lbu5", 1'b0, 3'd4, 5'd5, 2'd0, 32'd0);
    chk("lbu5/const", last_rdata, 32'h0000_00FF);
    do_req("lh5", 1'b0, 3'd1, 5'd5, 2'd2, 32'd0);
    chk("lh5/const", last_rdata, 32'hFFFF_8001);
    do_req("lhu5", 1'b0, 3'd5, 5'd5, 2'd2, 32'd0);
    chk("lhu5/const", last_rdata, 32'h0000_8001);

    // Response backpressure; an SW presented meanwhile must be ignored.
    model(1'b0, 3'd2, 5'd5, 2'd0, 32'd0, erd, eerr, elat);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 5'd5; req_byte_off = 2'd0;
    step();
    req_valid = 1'b0;
    cyc = 0;
    while (!resp_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("bp/latency", 32'(cyc), 32'(elat));
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 5'd5;
      req_wdata = 32'h5555_5555;
      chk("bp/resp_valid", 32'(resp_valid), 32'd1);
      chk("bp/resp_rdata", resp_rdata, erd);
      chk("bp/req_ready", 32'(req_ready), 32'd0);
      step();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    chk("bp/still_valid", 32'(resp_valid), 32'd1);
    step();
    chk("bp/released", 32'(resp_valid), 32'd0);
    chk("bp/ready_back", 32'(req_ready), 32'd1);
    do_req("bp_readback", 1'b0, 3'd2, 5'd5, 2'd0, 32'd0);

    // Illegal funct3.
    do_req("ill_st", 1'b1, 3'd3, 5'd5, 2'd0, 32'h1111_2222);
    chk("ill_st/err_const", 32'(last_err), 32'd1);
    do_req("ill_rb", 1'b0, 3'd2, 5'd5, 2'd0, 32'd0);
    chk("ill_rb/const", last_rdata, 32'h8001_F0FF);
    do_req("ill_ld", 1'b0, 3'd7, 5'd5, 2'd0, 32'd0);
    chk("ill_ld/err_const", 32'(last_err), 32'd1);

    // Misaligned word load.
    do_req("lw_off1", 1'b0, 3'd2, 5'd5, 2'd1, 32'd0);

    // Reset during WAIT of a pending SW.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 5'd7; req_byte_off = 2'd0;
    req_wdata = 32'h1234_5678;
    step();
    req_valid = 1'b0;
    Reset = 1'b1;
    step();
    chk("midrst/req_ready", 32'(req_ready), 32'd0);
    chk("midrst/resp_valid", 32'(resp_valid), 32'd0);
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
    step();
    do_req("midrst_lw7", 1'b0, 3'd2, 5'd7, 2'd0, 32'd0);
    chk("midrst_lw7/const", last_rdata, 32'd0);

    // Random traffic on a few addresses so loads hit earlier stores.
    for (int i = 0; i < 150; i++) begin
      do_req("rand", 1'($urandom), 3'($urandom), 5'($urandom_range(0, 7)), 2'($urandom),
             $urandom);
    end
    for (int a = 0; a < 8; a++) do_req("final_rb", 1'b0, 3'd2, 5'(a), 2'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
